// File: rtl/render_sequencer.sv
// render_sequencer: per-frame controller that sequences background erase,
// sprite draw and position update, and owns the VGA adapter write port.
module render_sequencer #(
  parameter int FRAME_CYCLES = 833334,
  parameter int NUM_SPRITES  = 4,
  parameter int ERASE_LAT    = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  output logic       go_erase,
  input  logic       done_erase,
  input  logic [7:0] erase_x,
  input  logic [6:0] erase_y,
  input  logic [2:0] erase_colour,
  output logic       go_draw,
  output logic [3:0] sprite_idx,
  input  logic       done_draw,
  input  logic [7:0] draw_x,
  input  logic [6:0] draw_y,
  input  logic [2:0] draw_colour,
  input  logic       draw_plot,
  output logic       update_pos,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       frame_overrun
);

  localparam int CNT_W = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  // With zero sprites the draw phase is never entered, so this value is unused.
  localparam logic [3:0] LAST_IDX = (NUM_SPRITES > 0) ? 4'(NUM_SPRITES - 1) : 4'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERASE,
    S_DRAW_START,
    S_DRAW_WAIT,
    S_UPDATE,
    S_WAIT_FRAME
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 pending_q, pending_d;
  logic                 overrun_q, overrun_d;
  logic [3:0]           sprite_idx_q, sprite_idx_d;
  logic                 go_erase_q, go_erase_d;
  logic                 go_draw_q, go_draw_d;
  logic                 update_pos_q, update_pos_d;
  logic                 busy_q, busy_d;
  logic [ERASE_LAT-1:0] erase_dly_q, erase_dly_d;
  logic                 tick;
  logic                 start_frame;
  logic                 erase_sel;

  assign tick        = (cnt_q == CNT_LAST);
  assign start_frame = (state_q == S_WAIT_FRAME) && enable && pending_q;
  assign erase_sel   = erase_dly_q[ERASE_LAT-1];

  // Free-running frame counter, pending-tick flag and sticky overrun flag.
  always_comb begin
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    pending_d = pending_q;
    if (tick && (state_q != S_IDLE)) begin
      pending_d = 1'b1;
    end else if (start_frame) begin
      pending_d = 1'b0;
    end
    overrun_d = overrun_q | (tick & pending_q & ~start_frame);
  end

  // Phase sequencing: erase, draw each sprite, update, wait for next tick.
  always_comb begin
    state_d      = state_q;
    sprite_idx_d = sprite_idx_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_ERASE;
      end
      S_ERASE: begin
        if (done_erase) begin
          if (NUM_SPRITES == 0) begin
            state_d = S_UPDATE;
          end else begin
            sprite_idx_d = 4'd0;
            state_d      = S_DRAW_START;
          end
        end
      end
      // A done_draw coincident with the go_draw pulse completes the sprite.
      S_DRAW_START, S_DRAW_WAIT: begin
        state_d = S_DRAW_WAIT;
        if (done_draw) begin
          if (sprite_idx_q == LAST_IDX) begin
            state_d = S_UPDATE;
          end else begin
            sprite_idx_d = sprite_idx_q + 4'd1;
            state_d      = S_DRAW_START;
          end
        end
      end
      S_UPDATE: begin
        state_d = S_WAIT_FRAME;
      end
      S_WAIT_FRAME: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (pending_q) begin
          state_d = S_ERASE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered Moore outputs decoded from the upcoming state, plus erase-delay pipe.
  always_comb begin
    go_erase_d   = (state_d == S_ERASE);
    go_draw_d    = (state_d == S_DRAW_START);
    update_pos_d = (state_d == S_UPDATE);
    busy_d       = (state_d == S_ERASE) || (state_d == S_DRAW_START) ||
                   (state_d == S_DRAW_WAIT) || (state_d == S_UPDATE);
    erase_dly_d    = '0;
    erase_dly_d[0] = go_erase_q;
    for (int i = 1; i < ERASE_LAT; i++) begin
      erase_dly_d[i] = erase_dly_q[i-1];
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      sprite_idx_q <= 4'd0;
      go_erase_q   <= 1'b0;
      go_draw_q    <= 1'b0;
      update_pos_q <= 1'b0;
      busy_q       <= 1'b0;
      erase_dly_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      sprite_idx_q <= sprite_idx_d;
      go_erase_q   <= go_erase_d;
      go_draw_q    <= go_draw_d;
      update_pos_q <= update_pos_d;
      busy_q       <= busy_d;
      erase_dly_q  <= erase_dly_d;
    end
  end

  // VGA write-port mux; trailing erase pixels win over draw pixels.
  always_comb begin
    vga_x      = 8'd0;
    vga_y      = 7'd0;
    vga_colour = 3'd0;
    vga_plot   = 1'b0;
    if (erase_sel) begin
      vga_x      = erase_x;
      vga_y      = erase_y;
      vga_colour = erase_colour;
      vga_plot   = 1'b1;
    end else if ((state_q == S_DRAW_START) || (state_q == S_DRAW_WAIT)) begin
      vga_x      = draw_x;
      vga_y      = draw_y;
      vga_colour = draw_colour;
      vga_plot   = draw_plot;
    end
  end

  assign go_erase      = go_erase_q;
  assign go_draw       = go_draw_q;
  assign sprite_idx    = sprite_idx_q;
  assign update_pos    = update_pos_q;
  assign busy          = busy_q;
  assign frame_overrun = overrun_q;

endmodule
